// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART baud select encodings and half-period helper
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;

  typedef enum logic [1:0] {
    BAUD_SEL_2400  = 2'b00,
    BAUD_SEL_4800  = 2'b01,
    BAUD_SEL_9600  = 2'b10,
    BAUD_SEL_19200 = 2'b11
  } baud_sel_e;

  // round(clk_freq / (2*baud)) in integer arithmetic
  function automatic int unsigned half_period(input int unsigned clk_freq,
                                              input int unsigned baud);
    return (clk_freq + baud) / (2 * baud);
  endfunction

endpackage

// File: rtl/toggle_divider.sv
// rtl/toggle_divider.sv - counts half_count clocks then toggles div_out
module toggle_divider #(
  parameter int unsigned CNT_W = 14
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] half_count,
  input  logic             restart,
  output logic             div_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [CNT_W:0]   cnt_inc;

  // Terminal test on the widened increment covers cnt >= half_count-1 without wrapping
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    cnt_d   = cnt_inc[CNT_W-1:0];
    div_d   = div_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_inc >= {1'b0, half_count}) begin
      cnt_d = '0;
      div_d = ~div_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign div_out = div_q;

endmodule

// File: rtl/baud_rate_gen.sv
// rtl/baud_rate_gen.sv - selectable 50%-duty baud clock for the UART transmitter
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD_0   = 2400,
  parameter int unsigned BAUD_1   = 4800,
  parameter int unsigned BAUD_2   = 9600,
  parameter int unsigned BAUD_3   = 19200,
  parameter int unsigned CNT_W    = 14
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] baud_rate,
  output logic       baud_clk
);

  localparam logic [CNT_W-1:0] HALF_0 = CNT_W'(half_period(CLK_FREQ, BAUD_0));
  localparam logic [CNT_W-1:0] HALF_1 = CNT_W'(half_period(CLK_FREQ, BAUD_1));
  localparam logic [CNT_W-1:0] HALF_2 = CNT_W'(half_period(CLK_FREQ, BAUD_2));
  localparam logic [CNT_W-1:0] HALF_3 = CNT_W'(half_period(CLK_FREQ, BAUD_3));

  logic [1:0]       baud_rate_q, baud_rate_d;
  logic [CNT_W-1:0] half_sel;
  logic             restart;

  always_comb begin
    baud_rate_d = baud_rate;
    half_sel    = HALF_0;
    case (baud_sel_e'(baud_rate))
      BAUD_SEL_2400:  half_sel = HALF_0;
      BAUD_SEL_4800:  half_sel = HALF_1;
      BAUD_SEL_9600:  half_sel = HALF_2;
      BAUD_SEL_19200: half_sel = HALF_3;
      default:        half_sel = HALF_0;
    endcase
  end

  // A new select restarts the count so the new half-period always runs in full
  assign restart = (baud_rate != baud_rate_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_rate_q <= BAUD_SEL_2400;
    end else begin
      baud_rate_q <= baud_rate_d;
    end
  end

  toggle_divider #(
    .CNT_W(CNT_W)
  ) u_div (
    .clock      (clock),
    .reset_n    (reset_n),
    .half_count (half_sel),
    .restart    (restart),
    .div_out    (baud_clk)
  );

endmodule

// File: tb/tb_baud_rate_gen.sv
// tb/tb_baud_rate_gen.sv - directed self-checking bench for baud_rate_gen
module tb_baud_rate_gen;

  logic       clock;
  logic       reset_n;
  logic [1:0] baud_rate;
  logic       baud_clk;

  int checks = 0;
  int fails  = 0;

  baud_rate_gen dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .baud_rate (baud_rate),
    .baud_clk  (baud_clk)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Clocks from now until baud_clk changes level; -1 when the bound expires
  task automatic measure(input int limit, output int n);
    logic prev;
    prev = baud_clk;
    n = 0;
    do begin
      step();
      n++;
    end while (baud_clk == prev && n < limit);
    if (baud_clk == prev) n = -1;
  endtask

  task automatic change_sel(input logic [1:0] sel, input logic level, input string tag);
    baud_rate = sel;
    step();
    check({tag, "_no_toggle"}, int'(baud_clk), int'(level));
    check({tag, "_cnt_clear"}, int'(dut.u_div.cnt_q), 0);
  endtask

  initial begin
    int n, hi, lo, rises, falls, last_toggle;
    logic prev;

    reset_n   = 1'b0;
    baud_rate = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_baud", int'(baud_clk), 0);
      check("hold_cnt", int'(dut.u_div.cnt_q), 0);
    end
    reset_n = 1'b1;
    measure(30000, n);
    check("sel0_first_rise", n, 10417);
    check("sel0_first_level", int'(baud_clk), 1);

    // Asynchronous reset between edges while baud_clk is high
    step();
    step();
    #5 reset_n = 1'b0;
    #1;
    check("async_baud", int'(baud_clk), 0);
    check("async_cnt", int'(dut.u_div.cnt_q), 0);
    step();
    reset_n = 1'b1;
    measure(30000, n);
    check("async_first_rise", n, 10417);
    measure(30000, hi);
    check("sel0_high", hi, 10417);
    measure(30000, lo);
    check("sel0_low", lo, 10417);
    check("sel0_period", hi + lo, 20834);

    // 00 -> 01 mid-high
    repeat (20) step();
    change_sel(2'b01, 1'b1, "chg01");
    measure(30000, n);
    check("chg01_first_toggle", n, 5208);
    check("chg01_level", int'(baud_clk), 0);
    measure(30000, lo);
    check("sel1_low", lo, 5208);
    measure(30000, hi);
    check("sel1_high", hi, 5208);
    check("sel1_period", hi + lo, 10416);

    // 01 -> 10 mid-low
    repeat (20) step();
    change_sel(2'b10, 1'b0, "chg10");
    measure(30000, n);
    check("chg10_first_toggle", n, 2604);
    check("chg10_level", int'(baud_clk), 1);
    measure(30000, hi);
    check("sel2_high", hi, 2604);
    measure(30000, lo);
    check("sel2_low", lo, 2604);
    check("sel2_period", hi + lo, 5208);

    // 10 -> 11 mid-high, then ten periods for drift
    repeat (20) step();
    change_sel(2'b11, 1'b1, "chg11");
    measure(30000, n);
    check("chg11_first_toggle", n, 1302);
    check("chg11_level", int'(baud_clk), 0);
    rises = 0;
    falls = 0;
    last_toggle = 0;
    prev = baud_clk;
    for (int i = 1; i <= 26040; i++) begin
      step();
      if (baud_clk && !prev) rises++;
      if (!baud_clk && prev) falls++;
      if (baud_clk != prev) last_toggle = i;
      prev = baud_clk;
    end
    check("sel3_rises", rises, 10);
    check("sel3_falls", falls, 10);
    check("sel3_last_toggle", last_toggle, 26040);
    check("sel3_end_level", int'(baud_clk), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/baud_rate_gen.md
Name: baud_rate_gen

Overview:
- Programmable baud-clock generator for the UART transmitter.
- Divides the 50 MHz system clock into a 50%-duty square wave, baud_clk, at one of four standard baud rates chosen by a 2-bit select.
- baud_clk is a registered, glitch-free signal.
- The Tx shift/FSM logic consumes baud_clk; one baud_clk period equals one UART bit time.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_0, 2400: rate for select 2'b00.
- BAUD_1, 4800: rate for select 2'b01.
- BAUD_2, 9600: rate for select 2'b10.
- BAUD_3, 19200: rate for select 2'b11.
- CNT_W, 14: divider counter width. Must hold the largest half-period minus 1; 10416 needs 14 bits.

Ports:
- clock, input, 1: system clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- baud_rate, input, 2: rate select; 00=2400, 01=4800, 10=9600, 11=19200.
- baud_clk, output, 1: generated baud clock, 50% duty, registered.

Behaviour:
- Half-period constant per select: HALF_n = round(CLK_FREQ / (2*BAUD_n)).
- Values at 50 MHz: 10417, 5208, 2604, 1302.
- Full baud_clk period is 2*HALF_n clocks: 20834, 10416, 5208, 2604.
- Constants are computed at elaboration; no runtime division.
- State: counter cnt[CNT_W-1:0] and the baud_clk register; both reset to 0 asynchronously while reset_n=0.
- Each rising clock edge (reset_n=1):
  - if cnt == HALF_sel-1: cnt <= 0, baud_clk <= ~baud_clk;
  - else: cnt <= cnt+1.
- Latency: after reset release, the first rising edge of baud_clk occurs exactly HALF_sel clocks later. Toggles then repeat every HALF_sel clocks.
- Rate change: baud_rate is sampled every cycle.
  - A change in value, detected with a registered copy of baud_rate, clears cnt to 0 on the next edge and does not toggle baud_clk.
  - The new half-period then runs in full before the next toggle.
  - The reset value of the registered copy is 2'b00.
- Safety: if cnt >= HALF_sel-1 (possible only transiently), treat it as terminal: cnt <= 0 and toggle. The counter never wraps through 2^CNT_W.
- Reset mid-operation: cnt and baud_clk return to 0 immediately, regardless of clock; counting restarts from 0 on release.
- No other outputs. No enable; the generator free-runs whenever out of reset.

Decomposition:
- Shared package uart_pkg holds:
  - baud select encodings: BAUD_SEL_2400=2'b00, BAUD_SEL_4800=2'b01, BAUD_SEL_9600=2'b10, BAUD_SEL_19200=2'b11;
  - default CLK_FREQ;
  - a function computing the half-period from (CLK_FREQ, baud). The Rx-side oversampling generator reuses these.
- One sub-module is natural: toggle_divider.
  - Inputs: clock, reset_n, half_count[CNT_W-1:0], restart.
  - Output: toggling div_out.
- baud_rate_gen does select decoding, change detection and instantiation.

Test Plan:
- Reset hold: reset_n=0 for 100 ns with the clock running. Required: baud_clk=0 and cnt=0 throughout; baud_clk stays 0 for exactly 10417 clocks after release with select 00.
- Select 00 (2400): measure successive baud_clk rising-edge intervals. Required: 20834 clocks (416.68 µs); high and low each 10417 clocks.
- Select 01, 10, 11 from reset, each run separately. Required: periods of 10416, 5208 and 2604 clocks respectively; duty exactly 50%.
- Sweep select 0..3, holding each for 770000/(i+1) ns. Required:
  - each change clears the counter with no toggle on the change edge;
  - the first toggle after a change lands HALF_new clocks later;
  - no runt pulse shorter than min(HALF_old, HALF_new) clocks.
- Asynchronous reset mid-count: assert reset_n between clock edges while baud_clk=1. Required: baud_clk falls to 0 without waiting for a clock edge; after release the first toggle comes HALF_sel clocks later.
- Static select after many periods (≥10 for 19200). Required: no cumulative drift; the edge count matches expected periods exactly.
